// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Scoreboard entries hold a fixed-width rd; narrower register addresses are zero-extended.
package hazard_pkg;

    localparam int SB_RD_W   = 8;
    localparam int DEPTH_DEF = 3;
    localparam int FWD_W     = $clog2(DEPTH_DEF + 1);
    localparam int FWD_RF    = 0;

    typedef struct packed {
        logic               vld;
        logic [SB_RD_W-1:0] rd;
        logic               wr;
        logic               ld;
    } sb_entry_t;

    function automatic int fwd_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Per-operand forwarding select: finds the youngest in-flight producer of rs
// and flags a load whose data is not yet available at that stage.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  sb_entry_t [DEPTH:1]   sb,
    output logic [SEL_W-1:0]      sel,
    output logic                  load_haz
);

    // Walk oldest to youngest so the last hit (smallest k) wins.
    always_comb begin
        sel      = SEL_W'(FWD_RF);
        load_haz = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (used && (rs != '0) && sb[k].vld && sb[k].wr &&
                (sb[k].rd == SB_RD_W'(rs))) begin
                sel      = SEL_W'(k);
                load_haz = sb[k].ld && (k < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: scoreboard of DEPTH post-decode stages,
// forwarding selects, load-use stall and redirect flush. HAZARD_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int N_SRC      = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    localparam int SEL_W     = fwd_width(DEPTH)
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        enable,
    input  logic                        id_valid,
    input  logic [N_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [N_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]       id_rd,
    input  logic                        id_reg_write,
    input  logic                        id_is_load,
    input  logic                        redirect,
    output logic                        stall,
    output logic                        flush,
    output logic [N_SRC*SEL_W-1:0]      fwd_sel,
    output logic [DEPTH-1:0]            stage_vld
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 flush_cnt
`endif
);

    sb_entry_t [DEPTH:1] sb_q;
    sb_entry_t           sb_in;
    logic [N_SRC-1:0]    haz_vec;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        fwd_select #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_fwd_select (
            .rs       (id_rs[g*REG_ADDR_W +: REG_ADDR_W]),
            .used     (id_rs_used[g]),
            .sb       (sb_q),
            .sel      (fwd_sel[g*SEL_W +: SEL_W]),
            .load_haz (haz_vec[g])
        );
    end

    assign flush = redirect;
    assign stall = id_valid & (|haz_vec) & ~redirect;

    always_comb begin
        sb_in = '0;
        if (id_valid && !stall && !flush) begin
            sb_in.vld = 1'b1;
            sb_in.rd  = SB_RD_W'(id_rd);
            sb_in.wr  = id_reg_write;
            sb_in.ld  = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sb_q <= '0;
        end else if (enable) begin
            sb_q <= {sb_q[DEPTH-1:1], sb_in};
        end
    end

    always_comb begin
        stage_vld = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            stage_vld[k-1] = sb_q[k].vld;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (enable) begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
            if (flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: queue-based pipeline model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pipe_hazard_ctrl;

    localparam int W  = 5;
    localparam int NS = 2;
    localparam int D  = 3;
    localparam int LS = 2;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          enable = 1'b1;
    logic          id_valid = 1'b0;
    logic [NS*W-1:0] id_rs = '0;
    logic [NS-1:0] id_rs_used = '0;
    logic [W-1:0]  id_rd = '0;
    logic          id_reg_write = 1'b0;
    logic          id_is_load = 1'b0;
    logic          redirect = 1'b0;
    logic          stall;
    logic          flush;
    logic [NS*FW-1:0] fwd_sel;
    logic [D-1:0]  stage_vld;
`ifdef HAZARD_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
    logic [31:0]   m_sc;
    logic [31:0]   m_fc;
    logic [31:0]   sc0;
    logic [31:0]   fc0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_ADDR_W (W),
        .N_SRC      (NS),
        .DEPTH      (D),
        .LOAD_STAGE (LS)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .enable       (enable),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .redirect     (redirect),
        .stall        (stall),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stage_vld    (stage_vld)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: one entry per in-flight instruction, index 0 = youngest (EX).
    typedef struct {
        bit vld;
        int rd;
        bit wr;
        bit ld;
    } ment_t;

    ment_t mq[$];

    function automatic void m_clear();
        ment_t e;
        e.vld = 0; e.rd = 0; e.wr = 0; e.ld = 0;
        mq.delete();
        for (int k = 0; k < D; k++) mq.push_back(e);
    endfunction

    function automatic int m_fwd(int rs, bit used);
        if (!used || rs == 0) return 0;
        for (int k = 0; k < D; k++)
            if (mq[k].vld && mq[k].wr && mq[k].rd == rs) return k + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        bit h = 0;
        for (int i = 0; i < NS; i++) begin
            int f;
            f = m_fwd(int'(id_rs[i*W +: W]), id_rs_used[i]);
            if (f != 0 && mq[f-1].ld && f < LS) h = 1;
        end
        return id_valid && h && !redirect;
    endfunction

    function automatic logic [NS*FW-1:0] m_fwd_bus();
        logic [NS*FW-1:0] r = '0;
        for (int i = 0; i < NS; i++)
            r[i*FW +: FW] = FW'(m_fwd(int'(id_rs[i*W +: W]), id_rs_used[i]));
        return r;
    endfunction

    function automatic logic [D-1:0] m_vld_bus();
        logic [D-1:0] r = '0;
        for (int k = 0; k < D; k++) r[k] = mq[k].vld;
        return r;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_clear();
`ifdef HAZARD_PERF_EN
            m_sc = 0;
            m_fc = 0;
`endif
        end else if (enable) begin
            ment_t e;
            bit    s;
            s = m_stall();
            e.vld = 0; e.rd = 0; e.wr = 0; e.ld = 0;
            if (id_valid && !s && !redirect) begin
                e.vld = 1;
                e.rd  = int'(id_rd);
                e.wr  = id_reg_write;
                e.ld  = id_is_load;
            end
`ifdef HAZARD_PERF_EN
            if (s && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (redirect && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
`endif
            mq.push_front(e);
            void'(mq.pop_back());
        end
    end

    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("flush", 32'(flush), 32'(redirect));
        chk("fwd_sel", 32'(fwd_sel), 32'(m_fwd_bus()));
        chk("stage_vld", 32'(stage_vld), 32'(m_vld_bus()));
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", stall_cnt, m_sc);
        chk("flush_cnt", flush_cnt, m_fc);
`endif
    end

    task automatic drv(input bit v, input int rs1, input int rs0, input bit [1:0] used,
                       input int rd, input bit wr, input bit ld, input bit rdr);
        id_valid     = v;
        id_rs        = {5'(rs1), 5'(rs0)};
        id_rs_used   = used;
        id_rd        = 5'(rd);
        id_reg_write = wr;
        id_is_load   = ld;
        redirect     = rdr;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0);
        repeat (D) tick();
    endtask

    initial begin
        m_clear();
        arst_n = 1'b0;
        drv(1, 2, 1, 2'b11, 0, 0, 0, 0);
        tick();
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_fwd", 32'(fwd_sel), 0);
        chk("rst_vld", 32'(stage_vld), 0);
        arst_n = 1'b1;
        drain();

        // ALU producer forwarded from EX, MEM, WB
        drv(1, 0, 0, 2'b00, 3, 1, 0, 0);
        tick();
        drv(1, 3, 3, 2'b11, 7, 0, 0, 0);
        #1 chk("fwd_ex", 32'(fwd_sel), 32'b0101);
        tick();
        drv(1, 0, 3, 2'b01, 7, 0, 0, 0);
        #1 chk("fwd_mem", 32'(fwd_sel), 32'b0010);
        tick();
        drv(1, 3, 0, 2'b10, 7, 0, 0, 0);
        #1 chk("fwd_wb", 32'(fwd_sel), 32'b1100);
        drain();

        // Load-use: one stall cycle, then forward from stage 2
        drv(1, 0, 0, 2'b00, 4, 1, 1, 0);
        tick();
        drv(1, 4, 4, 2'b11, 5, 1, 0, 0);
        #1;
        chk("lu_stall", 32'(stall), 1);
        chk("lu_fwd_ex", 32'(fwd_sel), 32'b0101);
        tick();
        #1;
        chk("lu_stall_end", 32'(stall), 0);
        chk("lu_fwd_mem", 32'(fwd_sel), 32'b1010);
        chk("lu_bubble", 32'(stage_vld), 32'b010);
        tick();
        #1 chk("lu_issue", 32'(stage_vld), 32'b101);
        drain();

        // Youngest producer wins; unused operand never forwards
        drv(1, 0, 0, 2'b00, 6, 1, 0, 0);
        tick();
        drv(1, 0, 0, 2'b00, 9, 0, 0, 0);
        tick();
        drv(1, 0, 0, 2'b00, 6, 1, 0, 0);
        tick();
        drv(1, 6, 6, 2'b11, 10, 0, 0, 0);
        #1;
        chk("young_fwd", 32'(fwd_sel), 32'b0101);
        chk("young_vld", 32'(stage_vld), 32'b111);
        drv(1, 6, 6, 2'b01, 10, 0, 0, 0);
        #1 chk("unused_fwd", 32'(fwd_sel), 32'b0001);
        drain();

        // r0 never matches, even against an in-flight load to r0
        drv(1, 0, 0, 2'b00, 0, 1, 1, 0);
        tick();
        drv(1, 0, 0, 2'b11, 1, 0, 0, 0);
        #1;
        chk("r0_fwd", 32'(fwd_sel), 0);
        chk("r0_stall", 32'(stall), 0);
        drain();

        // Redirect beats load-use stall
        drv(1, 0, 0, 2'b00, 4, 1, 1, 0);
        tick();
        drv(1, 4, 0, 2'b10, 5, 1, 0, 1);
        #1;
        chk("rdr_flush", 32'(flush), 1);
        chk("rdr_stall", 32'(stall), 0);
`ifdef HAZARD_PERF_EN
        sc0 = stall_cnt;
        fc0 = flush_cnt;
`endif
        tick();
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0);
        #1;
        chk("rdr_bubble", 32'(stage_vld), 32'b010);
`ifdef HAZARD_PERF_EN
        chk("rdr_flush_cnt", flush_cnt, fc0 + 1);
        chk("rdr_stall_cnt", stall_cnt, sc0);
`endif
        drain();

        // enable low freezes the scoreboard
        drv(1, 0, 0, 2'b00, 8, 1, 0, 0);
        tick();
        drv(1, 0, 0, 2'b00, 9, 1, 0, 0);
        tick();
        enable = 1'b0;
        drv(1, 8, 9, 2'b11, 10, 0, 0, 0);
        repeat (4) begin
            #1;
            chk("hold_fwd", 32'(fwd_sel), 32'b1001);
            chk("hold_vld", 32'(stage_vld), 32'b011);
            tick();
        end
        enable = 1'b1;
        drain();

        // Async reset in the middle of a stall
        drv(1, 0, 0, 2'b00, 4, 1, 1, 0);
        tick();
        drv(1, 4, 4, 2'b11, 5, 1, 0, 0);
        #1 chk("pre_rst_stall", 32'(stall), 1);
        arst_n = 1'b0;
        #1;
        chk("async_rst_stall", 32'(stall), 0);
        chk("async_rst_vld", 32'(stage_vld), 0);
        tick();
        arst_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
